// File: rtl/booth_mul_seq.sv
// Sequential signed 8x8 radix-2 Booth multiplier with start/done handshake, plus the shared adder_subtractor.
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips the Booth steps and completes with product 0.

module adder_subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       op,
  output logic [7:0] s,
  output logic       overflow
);
  logic [7:0] w_b;

  // Subtraction as a + ~b + 1
  assign w_b      = op ? ~b : b;
  assign s        = a + w_b + {7'd0, op};
  assign overflow = (a[7] == w_b[7]) && (s[7] != a[7]);
endmodule

module booth_mul_seq (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [7:0]  mcand,
  input  logic signed [7:0]  mplier,
  output logic               ready,
  output logic               done,
  output logic signed [15:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic signed [7:0]  r_a;
  logic signed [7:0]  r_q;
  logic               r_q1;
  logic signed [7:0]  r_m;
  logic [2:0]         r_cnt;
  logic signed [15:0] r_product;

  logic [1:0]         w_booth;
  logic               w_arith;
  logic               w_op;
  logic [7:0]         w_s;
  logic               w_ovf;
  logic               w_t;
  logic signed [7:0]  w_a_nxt;
  logic signed [7:0]  w_q_nxt;
  logic               w_zero;

`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_zero = (mcand == 8'sd0) || (mplier == 8'sd0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_booth = {r_q[0], r_q1};
  assign w_arith = (w_booth == 2'b01) || (w_booth == 2'b10);
  assign w_op    = (w_booth == 2'b10);

  adder_subtractor u_addsub (
    .s        (w_s),
    .overflow (w_ovf),
    .a        (r_a),
    .b        (r_m),
    .op       (w_op)
  );

  // The adder result is really 9 bits wide; overflow flips bit 7 back to the true sign
  assign w_t = w_s[7] ^ w_ovf;

  always_comb begin
    w_a_nxt = r_a;
    w_q_nxt = r_q;
    if (w_arith) begin
      w_a_nxt = {w_t, w_s[7:1]};
      w_q_nxt = {w_s[0], r_q[7:1]};
    end else begin
      w_a_nxt = {r_a[7], r_a[7:1]};
      w_q_nxt = {r_a[0], r_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? (w_zero ? S_DONE : S_CALC) : S_IDLE;
      S_CALC:  w_state_nxt = (r_cnt == 3'd7) ? S_DONE : S_CALC;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_zero) begin
            r_product <= '0;
          end else if (start) begin
            r_a   <= '0;
            r_q   <= mplier;
            r_q1  <= 1'b0;
            r_m   <= mcand;
            r_cnt <= '0;
          end
        end
        S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_product <= {w_a_nxt, w_q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Randomized self-checking bench for booth_mul_seq against a plain signed-multiply reference.

module tb_booth_mul_seq;
  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [7:0]  mcand;
  logic signed [7:0]  mplier;
  logic               ready;
  logic               done;
  logic signed [15:0] product;

  int n_cmp = 0;
  int n_err = 0;

  booth_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic signed [7:0] m, input logic signed [7:0] q);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (m == 0 || q == 0) return 0;
`endif
    return 8;
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) chk({tag, " ready_timeout"}, 0, 1);
  endtask

  // One full transaction; k counts edges after the accepting edge
  task automatic run_op(input logic signed [7:0] m, input logic signed [7:0] q, input string tag);
    logic signed [15:0] e;
    logic signed [15:0] prev;
    int lat;
    int ndone;
    int both;
    int held_bad;
    int el;
    e     = m * q;
    el    = exp_latency(m, q);
    wait_ready(tag);
    prev  = product;
    start = 1'b1;
    mcand = m;
    mplier = q;
    lat = -1; ndone = 0; both = 0; held_bad = 0;
    for (int k = 0; k <= el + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk({tag, " ready_drop"}, ready, 0);
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (ready && done) both++;
      if (k < el && product !== prev) held_bad++;
      if (k == 0) begin
        @(negedge clk);
        start  = 1'b0;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
      end
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " product"}, product, e);
    chk({tag, " ready_back"}, ready, 1);
    chk({tag, " done_low"}, done, 0);
    chk({tag, " ready_done_excl"}, both, 0);
    chk({tag, " product_held"}, held_bad, 0);
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1;
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    chk("reset product", product, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'sd3, 8'sd5, "3x5");
    run_op(-8'sd128, -8'sd128, "m128xm128");
    run_op(8'sd127, -8'sd1, "127xm1");
    run_op(-8'sd127, -8'sd15, "m127xm15");
    run_op(-8'sd1, -8'sd1, "m1xm1");
    run_op(8'sd1, -8'sd128, "1xm128");
    run_op(8'sd0, 8'sd55, "0x55");

    // Second start during CALC must be ignored
    wait_ready("ign");
    start = 1'b1; mcand = 8'sd7; mplier = 8'sd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mcand = 8'sd2; mplier = 8'sd2;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignore product", product, 63);
    chk("ignore done_count", ndone, 1);

    // Reset during CALC aborts without a done
    wait_ready("rst");
    start = 1'b1; mcand = 8'sd10; mplier = 8'sd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    chk("abort product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    chk("abort product_kept", product, 0);
    run_op(8'sd2, 8'sd3, "after_abort");

    // Random back-to-back traffic with occasional corner operands
    for (int i = 0; i < 40; i++) begin
      logic signed [7:0] m;
      logic signed [7:0] q;
      m = 8'($urandom);
      q = 8'($urandom);
      case ($urandom_range(0, 7))
        0: m = -8'sd128;
        1: q = -8'sd128;
        2: m = 8'sd0;
        3: q = 8'sd127;
        default: ;
      endcase
      run_op(m, q, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
